// File: rtl/imem_program_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StHdr,
      StData,
      StWrite,
      StVrd,
      StVcmp,
      StDone,
      StError
   } state_e;

   localparam int unsigned HDR_BYTES      = 4;
   localparam int unsigned BYTES_PER_WORD = 4;
   localparam int unsigned SUM_W          = 32;

endpackage

// File: rtl/imem_program_loader_if.sv
// Byte stream handshake plus the instruction-memory external port.
// The loader drives the memory side (master); stream source and memory sit on the slave side.
interface imem_program_loader_if;

   logic [7:0]  s_data;
   logic        s_valid;
   logic        s_ready;
   logic [63:0] addr_ext;
   logic        wen_ext;
   logic        ren_ext;
   logic [31:0] wdata_ext;
   logic [31:0] rdata_ext;

   modport master (
      input  s_data, s_valid, rdata_ext,
      output s_ready, addr_ext, wen_ext, ren_ext, wdata_ext
   );

   modport slave (
      output s_data, s_valid, rdata_ext,
      input  s_ready, addr_ext, wen_ext, ren_ext, wdata_ext
   );

endinterface

// File: rtl/imem_program_loader_byte_packer.sv
// Little-endian byte-to-word packer shared by the header and data phases.
// The word is presented combinationally together with the 4th accepted byte.
module byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        arst_n,
   input  logic        clear,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic [31:0] word,
   output logic        word_valid
);

   localparam int unsigned CntW = $clog2(BYTES_PER_WORD);

   logic [31:0]     shift_q;
   logic [CntW-1:0] cnt_q;

   // Newest byte enters at the top, so after four shifts the first byte sits in [7:0].
   assign word       = {in_data, shift_q[31:8]};
   assign word_valid = in_valid && (cnt_q == CntW'(BYTES_PER_WORD - 1));

   // Shift register and byte counter; the counter wraps to 0 after each full word.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else if (clear) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else if (in_valid) begin
         shift_q <= word;
         cnt_q   <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/imem_program_loader.sv
// Streaming program loader: header word count N, then N little-endian words written to
// instruction memory, after which cpu_enable is raised. Optional readback checksum verify
// is compiled in with the IMEM_LOADER_VERIFY_EN macro.
module imem_program_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned MAX_WORDS = 128,
   parameter int unsigned CNT_W     = 16
) (
   input  logic                  clk,
   input  logic                  arst_n,
   input  logic                  start,
   imem_program_loader_if.master bus,
   output logic                  cpu_enable,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [CNT_W-1:0]      words_loaded
);

   state_e           state_q;
   logic             s_ready_q;
   logic             wen_q;
   logic [CNT_W+1:0] addr_q;
   logic [31:0]      wdata_q;
   logic             cpu_enable_q;
   logic             busy_q;
   logic             done_q;
   logic             error_q;
   logic [CNT_W-1:0] words_q;
   logic [CNT_W-1:0] idx_q;
   logic [CNT_W-1:0] n_q;

   logic             accept;
   logic             restart;
   logic [31:0]      pk_word;
   logic             pk_valid;
   logic [CNT_W-1:0] idx_inc;
   logic             last_word;
   logic [CNT_W-1:0] hdr_n;
   logic             hdr_bad;

   assign accept    = bus.s_valid && s_ready_q;
   assign restart   = start && ((state_q == StIdle) || (state_q == StDone));
   assign idx_inc   = idx_q + 1'b1;
   assign last_word = (idx_inc == n_q);
   assign hdr_n     = pk_word[CNT_W-1:0];
   assign hdr_bad   = (hdr_n == '0) || (hdr_n > CNT_W'(MAX_WORDS));

   byte_packer u_packer (
      .clk        (clk),
      .arst_n     (arst_n),
      .clear      (restart),
      .in_valid   (accept),
      .in_data    (bus.s_data),
      .word       (pk_word),
      .word_valid (pk_valid)
   );

`ifdef IMEM_LOADER_VERIFY_EN
   logic             ren_q;
   logic [SUM_W-1:0] sum_w_q;
   logic [SUM_W-1:0] sum_r_q;
   logic [SUM_W-1:0] sum_r_nxt;

   assign sum_r_nxt   = sum_r_q + bus.rdata_ext;
   assign bus.ren_ext = ren_q;
`else
   logic unused_rdata;

   assign unused_rdata = ^bus.rdata_ext;
   assign bus.ren_ext  = 1'b0;
`endif

   assign bus.s_ready   = s_ready_q;
   assign bus.wen_ext   = wen_q;
   assign bus.addr_ext  = {{(64 - CNT_W - 2){1'b0}}, addr_q};
   assign bus.wdata_ext = wdata_q;
   assign cpu_enable    = cpu_enable_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;
   assign words_loaded  = words_q;

   // Load sequencer; every output is registered here and set for the state being entered.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q      <= StIdle;
         s_ready_q    <= 1'b0;
         wen_q        <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cpu_enable_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         words_q      <= '0;
         idx_q        <= '0;
         n_q          <= '0;
`ifdef IMEM_LOADER_VERIFY_EN
         ren_q        <= 1'b0;
         sum_w_q      <= '0;
         sum_r_q      <= '0;
`endif
      end else begin
         wen_q <= 1'b0;
`ifdef IMEM_LOADER_VERIFY_EN
         ren_q <= 1'b0;
`endif
         unique case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  state_q      <= StHdr;
                  s_ready_q    <= 1'b1;
                  busy_q       <= 1'b1;
                  cpu_enable_q <= 1'b0;
                  done_q       <= 1'b0;
                  words_q      <= '0;
                  idx_q        <= '0;
`ifdef IMEM_LOADER_VERIFY_EN
                  sum_w_q      <= '0;
                  sum_r_q      <= '0;
`endif
               end
            end
            StHdr: begin
               if (pk_valid) begin
                  n_q <= hdr_n;
                  if (hdr_bad) begin
                     state_q   <= StError;
                     s_ready_q <= 1'b0;
                     busy_q    <= 1'b0;
                     error_q   <= 1'b1;
                  end else begin
                     state_q <= StData;
                  end
               end
            end
            StData: begin
               if (pk_valid) begin
                  state_q   <= StWrite;
                  s_ready_q <= 1'b0;
                  wen_q     <= 1'b1;
                  addr_q    <= {idx_q, 2'b00};
                  wdata_q   <= pk_word;
               end
            end
            StWrite: begin
               idx_q   <= idx_inc;
               words_q <= words_q + 1'b1;
`ifdef IMEM_LOADER_VERIFY_EN
               sum_w_q <= sum_w_q + wdata_q;
`endif
               if (!last_word) begin
                  state_q   <= StData;
                  s_ready_q <= 1'b1;
               end else begin
`ifdef IMEM_LOADER_VERIFY_EN
                  state_q <= StVrd;
                  ren_q   <= 1'b1;
                  addr_q  <= '0;
                  idx_q   <= '0;
`else
                  state_q      <= StDone;
                  busy_q       <= 1'b0;
                  cpu_enable_q <= 1'b1;
                  done_q       <= 1'b1;
`endif
               end
            end
`ifdef IMEM_LOADER_VERIFY_EN
            StVrd: begin
               state_q <= StVcmp;
            end
            StVcmp: begin
               sum_r_q <= sum_r_nxt;
               idx_q   <= idx_inc;
               if (!last_word) begin
                  state_q <= StVrd;
                  ren_q   <= 1'b1;
                  addr_q  <= {idx_inc, 2'b00};
               end else if (sum_r_nxt == sum_w_q) begin
                  state_q      <= StDone;
                  busy_q       <= 1'b0;
                  cpu_enable_q <= 1'b1;
                  done_q       <= 1'b1;
               end else begin
                  state_q <= StError;
                  busy_q  <= 1'b0;
                  error_q <= 1'b1;
               end
            end
`endif
            StError: begin
               // Terminal until reset; start is deliberately ignored.
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader with a write/read scoreboard and memory model.
`timescale 1ns/1ps
module tb_imem_program_loader;

   localparam int unsigned MaxWords = 128;
   localparam int unsigned CntW     = 16;

   typedef struct packed {
      logic [63:0] addr;
      logic [31:0] data;
   } wr_t;

   logic            clk = 1'b0;
   logic            arst_n;
   logic            start;
   logic            cpu_enable;
   logic            busy;
   logic            done;
   logic            error;
   logic [CntW-1:0] words_loaded;

   imem_program_loader_if bus ();

   imem_program_loader #(
      .MAX_WORDS (MaxWords),
      .CNT_W     (CntW)
   ) dut (
      .clk          (clk),
      .arst_n       (arst_n),
      .start        (start),
      .bus          (bus),
      .cpu_enable   (cpu_enable),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          last_wr_cyc = 0;
   wr_t         exp_wr[$];
   logic [63:0] exp_rd[$];
   logic [31:0] mem [0:MaxWords-1];
   bit          corrupt = 1'b0;
   wr_t         mon_e;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Instruction memory model; optionally corrupts word 1 on readback.
   always @(posedge clk) begin
      if (bus.wen_ext) mem[bus.addr_ext[8:2]] <= bus.wdata_ext;
      if (bus.ren_ext)
         bus.rdata_ext <= mem[bus.addr_ext[8:2]] ^
                          ((corrupt && bus.addr_ext[8:2] == 7'd1) ? 32'h1 : 32'h0);
   end

   // Scoreboard: every write/read strobe must match the next expected entry.
   always @(negedge clk) begin
      if (arst_n && bus.wen_ext) begin
         check("wr_expected", exp_wr.size() != 0, 1);
         if (exp_wr.size() != 0) begin
            mon_e = exp_wr.pop_front();
            check("wr_addr", bus.addr_ext, mon_e.addr);
            check("wr_data", bus.wdata_ext, mon_e.data);
         end
         check("s_ready_in_write", bus.s_ready, 0);
         last_wr_cyc <= cyc;
      end
      if (arst_n && bus.ren_ext) begin
         check("rd_expected", exp_rd.size() != 0, 1);
         if (exp_rd.size() != 0) check("rd_addr", bus.addr_ext, exp_rd.pop_front());
      end
   end

   function automatic int lat(input int n);
`ifdef IMEM_LOADER_VERIFY_EN
      return 2 * n + 1;
`else
      return 1 + 0 * n;
`endif
   endfunction

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gap);
      bit acc = 1'b0;
      if (gap) begin
         bus.s_valid = 1'b0;
         @(negedge clk);
      end
      bus.s_data  = b;
      bus.s_valid = 1'b1;
      for (int k = 0; k < 20 && !acc; k++) begin
         acc = bus.s_ready;
         @(negedge clk);
      end
      if (!acc) check("byte_accept_timeout", acc, 1);
   endtask

   task automatic send_word(input logic [31:0] w, input bit gap);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap);
   endtask

   task automatic load_words(input logic [31:0] hdr, input logic [31:0] words[$], input bit gap);
      for (int i = 0; i < words.size(); i++) begin
         exp_wr.push_back({64'(i * 4), words[i]});
`ifdef IMEM_LOADER_VERIFY_EN
         exp_rd.push_back(64'(i * 4));
`endif
      end
      send_word(hdr, gap);
      for (int i = 0; i < words.size(); i++) send_word(words[i], gap);
      bus.s_valid = 1'b0;
   endtask

   task automatic wait_end(input int budget, input bit exp_ok, input int exp_lat);
      int k = 0;
      while (!(cpu_enable || error) && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("end_reached", cpu_enable | error, 1);
      check("done", done, exp_ok);
      check("cpu_enable", cpu_enable, exp_ok);
      check("error", error, !exp_ok);
      check("busy_end", busy, 0);
      if (exp_ok) check("enable_latency", 64'(cyc - last_wr_cyc), 64'(exp_lat));
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_s_ready"}, bus.s_ready, 0);
      check({tag, "_wen"}, bus.wen_ext, 0);
      check({tag, "_ren"}, bus.ren_ext, 0);
      check({tag, "_addr"}, bus.addr_ext, 0);
      check({tag, "_wdata"}, bus.wdata_ext, 0);
      check({tag, "_cpu_enable"}, cpu_enable, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_error"}, error, 0);
      check({tag, "_words"}, words_loaded, 0);
   endtask

   task automatic do_reset();
      #2 arst_n = 1'b0;
      @(negedge clk);
      #2 arst_n = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] basic[$];
      logic [31:0] q[$];
      basic = '{32'h0000_0013, 32'hDEAD_BEEF};
      arst_n      = 1'b0;
      start       = 1'b0;
      bus.s_valid = 1'b0;
      bus.s_data  = 8'h00;
      repeat (2) @(negedge clk);
      check_reset_vals("reset");
      arst_n = 1'b1;
      @(negedge clk);

      // Stream bytes without start are ignored.
      bus.s_valid = 1'b1;
      bus.s_data  = 8'h55;
      repeat (3) @(negedge clk);
      check("idle_s_ready", bus.s_ready, 0);
      check("idle_busy", busy, 0);
      bus.s_valid = 1'b0;

      // Basic load.
      do_start();
      check("start_s_ready", bus.s_ready, 1);
      check("start_busy", busy, 1);
      load_words(32'd2, basic, 1'b0);
      wait_end(60, 1'b1, lat(2));
      check("basic_words", words_loaded, 2);
      check("basic_wr_left", exp_wr.size(), 0);

      // Reload from DONE with a single word.
      do_start();
      check("reload_cpu_enable", cpu_enable, 0);
      check("reload_done", done, 0);
      check("reload_words", words_loaded, 0);
      check("reload_s_ready", bus.s_ready, 1);
      q = '{32'h0010_0093};
      load_words(32'd1, q, 1'b0);
      wait_end(40, 1'b1, lat(1));
      check("reload_words_end", words_loaded, 1);

      // Gapped stream gives the same write sequence.
      do_start();
      load_words(32'd2, basic, 1'b1);
      wait_end(60, 1'b1, lat(2));
      check("gap_words", words_loaded, 2);
      check("gap_wr_left", exp_wr.size(), 0);

      // Header with bits above CNT_W set: only the low 16 bits (3) count.
      do_start();
      q = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
      load_words(32'h0001_0003, q, 1'b0);
      wait_end(60, 1'b1, lat(3));
      check("trunc_words", words_loaded, 3);

      // Largest legal count.
      do_start();
      q = {};
      for (int i = 0; i < MaxWords; i++) q.push_back($urandom);
      load_words(32'(MaxWords), q, 1'b0);
      wait_end(2 * MaxWords + 20, 1'b1, lat(MaxWords));
      check("max_words", words_loaded, MaxWords);
      check("max_wr_left", exp_wr.size(), 0);

      // Asynchronous reset after 6 data bytes.
      do_start();
      exp_wr.push_back({64'h0, 32'hCAFE_F00D});
      send_word(32'd2, 1'b0);
      send_word(32'hCAFE_F00D, 1'b0);
      send_byte(8'hA1, 1'b0);
      send_byte(8'hA2, 1'b0);
      bus.s_valid = 1'b0;
      #2 arst_n = 1'b0;
      #1 check_reset_vals("midreset");
      check("midreset_wr_left", exp_wr.size(), 0);
      @(negedge clk);
      #2 arst_n = 1'b1;
      @(negedge clk);
      do_start();
      load_words(32'd2, basic, 1'b0);
      wait_end(60, 1'b1, lat(2));
      check("after_reset_words", words_loaded, 2);

      // Zero count is an error; a later start does not clear it.
      do_start();
      send_word(32'd0, 1'b0);
      bus.s_valid = 1'b0;
      wait_end(10, 1'b0, 0);
      check("zero_s_ready", bus.s_ready, 0);
      do_start();
      @(negedge clk);
      check("zero_sticky_error", error, 1);
      check("zero_sticky_s_ready", bus.s_ready, 0);
      check("zero_sticky_busy", busy, 0);
      do_reset();
      check("zero_cleared", error, 0);

      // Count one past capacity.
      do_start();
      send_word(32'(MaxWords + 1), 1'b0);
      bus.s_valid = 1'b0;
      wait_end(10, 1'b0, 0);
      do_reset();

`ifdef IMEM_LOADER_VERIFY_EN
      // Readback of a corrupted word 1 ends in error after both reads.
      corrupt = 1'b1;
      do_start();
      load_words(32'd2, basic, 1'b0);
      wait_end(60, 1'b0, 0);
      check("verify_rd_left", exp_rd.size(), 0);
      check("verify_words", words_loaded, 2);
      corrupt = 1'b0;
      do_reset();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imem_program_loader.md
# imem_program_loader

Streaming program loader upstream of the pipelined RISC-V `cpu`. It accepts a byte stream over a valid/ready handshake and packs the bytes little-endian into 32-bit instructions. It writes those instructions into the instruction memory through the CPU's external port (`addr_ext`, `wen_ext`, `wdata_ext`), then raises `cpu_enable` so execution starts from address 0. The stream format is a 4-byte little-endian word count N, followed by N instruction words.

## Interface
Parameters:
- `MAX_WORDS`, default 128: capacity of the instruction memory in 32-bit words.
- `CNT_W`, default 16: width of the word counters and the `words_loaded` output.

Ports:
- `clk`  in  1: clock.
- `arst_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: single-cycle pulse that begins a load.
- `s_data`  in  8: stream byte.
- `s_valid`  in  1: `s_data` is valid.
- `s_ready`  out  1: loader can accept a byte this cycle.
- `addr_ext`  out  64: byte address into instruction memory.
- `wen_ext`  out  1: instruction memory write enable.
- `ren_ext`  out  1: instruction memory read enable.
- `wdata_ext`  out  32: write word.
- `rdata_ext`  in  32: read word. Valid one cycle after `ren_ext`.
- `cpu_enable`  out  1: drives the CPU `enable` input.
- `busy`  out  1: a load is in progress.
- `done`  out  1: load completed successfully.
- `error`  out  1: sticky error flag.
- `words_loaded`  out  `CNT_W`: number of words written so far.

## Operation
- States:
  - IDLE
  - HDR (collecting the 4 count bytes)
  - DATA (collecting 4 bytes per word)
  - WRITE
  - VRD (verify read)
  - VCMP (verify compare)
  - DONE
  - ERROR
- A byte is accepted only when `s_valid && s_ready` are both high.
- `s_ready` is 1 only in HDR and DATA.
- Bytes are little-endian: the first byte received goes to bits [7:0].
- IDLE:
  - `start` moves to HDR.
  - `s_valid` without `start` is ignored.
- HDR:
  - After the 4th byte, N is latched; only the low `CNT_W` bits are kept.
  - If N==0 or N>`MAX_WORDS`, go to ERROR.
  - Otherwise go to DATA.
- DATA → WRITE after the 4th byte of a word.
- WRITE is one cycle:
  - `wen_ext`=1, `addr_ext`={0, i<<2}, `wdata_ext`=packed word, where i is the word index.
  - i and `words_loaded` increment.
  - If i < N, go back to DATA; after the last word, go to VRD (verify compiled in) or DONE.
- DONE:
  - `cpu_enable`=1 and `done`=1, held.
  - A new `start` clears `cpu_enable`/`done` on the next cycle and re-enters HDR. `words_loaded` resets to 0 at that point.
- ERROR:
  - `error`=1, `cpu_enable`=0, `s_ready`=0.
  - `start` is ignored; only `arst_n` clears this state.
- `start` received in any state other than IDLE, DONE, or ERROR is ignored.
- `busy`=1 in HDR, DATA, WRITE, VRD and VCMP.
- `addr_ext` bits [63:CNT_W+2] are always 0.

## Timing
- Reset values:
  - State IDLE.
  - `s_ready`, `wen_ext`, `ren_ext`, `cpu_enable`, `busy`, `done`, `error` all 0.
  - `addr_ext`=0, `wdata_ext`=0, `words_loaded`=0.
  - Byte and word counters 0.
- Reset is asynchronous and takes effect at any point, including mid-load. `wen_ext` drops immediately with `arst_n`, so no partial write is issued.
- All outputs are registered.
- Throughput with continuous `s_valid`: 4 bytes per 5 cycles (4 accept cycles + 1 WRITE cycle with `s_ready`=0).
- With gaps in `s_valid`, the loader waits. There is no timeout.
- Latency: `cpu_enable` rises 1 cycle after the final WRITE cycle (no verify). With verify it rises 2N+1 cycles after the final WRITE cycle.
- `start` seen in IDLE: `s_ready` goes high the following cycle.

## Configuration
- Macro: `IMEM_LOADER_VERIFY_EN`.
- Defined:
  - During WRITE, a 32-bit wrapping sum S_w of all written words is accumulated.
  - After the last word, verify runs once per word:
    - VRD drives `ren_ext`=1 with `addr_ext`=i<<2.
    - VCMP adds `rdata_ext` into S_r.
  - After N words are read back: S_r==S_w goes to DONE, otherwise to ERROR.
- Undefined:
  - VRD, VCMP and both accumulators are absent.
  - `ren_ext` is tied to 0.
  - The last WRITE goes directly to DONE.

## Structure
- `imem_loader_pkg` holds:
  - the state enum;
  - `HDR_BYTES`=4;
  - `BYTES_PER_WORD`=4;
  - the sum width constant.
- One sub-module, `byte_packer`:
  - Shift-in register with 2-bit byte counter.
  - Asserts `word_valid` on the 4th accepted byte.
  - Cleared by the FSM.
  - Instanced once and shared by HDR and DATA.

## Test plan
- **Basic load.** Bytes 02 00 00 00 13 00 00 00 EF BE AD DE → two writes: addr 0x0 data 0x00000013, then addr 0x4 data 0xDEADBEEF. Afterwards `words_loaded`=2, `done`=1, `cpu_enable`=1.
- **Bad count.** Header 00 00 00 00 → `error`=1, no `wen_ext` pulses, `cpu_enable`=0. Header `MAX_WORDS`+1 (129) → `error`=1. A later `start` must not clear `error`.
- **Stream gaps.** Basic-load stream with `s_valid` toggled every other cycle → identical write sequence to the basic load; `s_ready` is 0 in every WRITE cycle.
- **Reset mid-load.** `arst_n` pulsed low after 6 data bytes → all outputs return to reset values. A following full basic-load sequence completes correctly.
- **Reload from DONE.** `start` in DONE → `cpu_enable` falls next cycle. A 1-word load of 0x00100093 writes addr 0x0 and re-enters DONE.
- **Verify (`IMEM_LOADER_VERIFY_EN`).** The memory model corrupts addr 0x4 before readback → `ren_ext` issued at addr 0x0 and 0x4, then `error`=1. Uncorrupted memory → `done`=1.
